// File: rtl/pbit_sweep_engine.sv
// pbit_sweep_engine
//
// Sequential-Gibbs sweep engine for a fully connected network of NPB
// probabilistic bits. Weights and biases are written in sign-magnitude
// (N bits, Q fractional bits) and stored as (N+clog2(NPB)+2)-bit two's
// complement. A sweep visits p-bits 0..NPB-1 in order. Each p-bit spends
// NPB accumulate cycles (ACC) and one update cycle (UPD). The new state
// of p-bit i is visible to the accumulation of p-bit i+1.
//
// Optional feature macro: PBIT_CLAMP_EN. When defined, clamp_mask and
// clamp_val force p-bit states during their UPD cycle. When undefined,
// those inputs are accepted but have no effect.
//
// Ports
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   run          level request; sweeps repeat while it is high
//   cfg_we       config write strobe, honoured only while idle
//   cfg_bias     1: write bias[cfg_row], 0: write w[cfg_row][cfg_col]
//   cfg_row/col  config indices (indices >= NPB are ignored)
//   cfg_data     sign-magnitude value to write
//   clamp_mask   per-p-bit force enable (PBIT_CLAMP_EN builds only)
//   clamp_val    per-p-bit forced value (PBIT_CLAMP_EN builds only)
//   busy         high whenever the FSM is not IDLE
//   out          p-bit states, 1 = +1, 0 = -1
//   sample_valid one-cycle pulse after the last UPD of a sweep
//   sweep_cnt    completed sweeps since reset, wraps at 16 bits
//   dbg_state    FSM state: 0 = IDLE, 1 = ACC, 2 = UPD
//
// Handshake: sample_valid is a valid-only pulse with no ready. The
// consumer must capture out and sweep_cnt in the cycle where
// sample_valid is high. Nothing stalls the engine.
module pbit_sweep_engine #(
  parameter int          NPB  = 8,
  parameter int          N    = 7,
  parameter int          Q    = 2,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   run,
  input  logic                   cfg_we,
  input  logic                   cfg_bias,
  input  logic [$clog2(NPB)-1:0] cfg_row,
  input  logic [$clog2(NPB)-1:0] cfg_col,
  input  logic [N-1:0]           cfg_data,
  input  logic [NPB-1:0]         clamp_mask,
  input  logic [NPB-1:0]         clamp_val,
  output logic                   busy,
  output logic [NPB-1:0]         out,
  output logic                   sample_valid,
  output logic [15:0]            sweep_cnt,
  output logic [1:0]             dbg_state
);

  localparam int IW = $clog2(NPB);
  localparam int AW = N + IW + 2;
  localparam logic signed [AW-1:0] ZMAX = AW'(2**(N-1) - 1);
  localparam logic signed [AW-1:0] ZMIN = -ZMAX;
  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, UPD = 2'd2} state_t;

  state_t               state;
  logic [IW-1:0]        pi;
  logic [IW-1:0]        pj;
  logic signed [AW-1:0] acc;
  logic [31:0]          lfsr;
  logic signed [AW-1:0] w    [NPB][NPB];
  logic signed [AW-1:0] bias [NPB];

  logic signed [AW-1:0] cfg_mag;
  logic signed [AW-1:0] cfg_tc;
  logic signed [AW-1:0] wij;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] z_sum;
  logic signed [AW-1:0] z_sat;
  logic signed [AW-1:0] r_tc;
  logic                 new_bit;
  logic [31:0]          lfsr_next;
  logic                 row_ok;
  logic                 col_ok;
  logic [NPB-1:0]       force_en;
  logic [NPB-1:0]       force_val;

`ifdef PBIT_CLAMP_EN
  assign force_en  = clamp_mask;
  assign force_val = clamp_val;
`else
  assign force_en  = '0;
  assign force_val = '0;
  logic unused_clamp;
  assign unused_clamp = ^{clamp_mask, clamp_val};
`endif

  // The fixed-point position only matters to software; the datapath is
  // pure integer LSB arithmetic.
  logic unused_frac;
  assign unused_frac = ^Q;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    // Sign-magnitude to two's complement; a negative zero comes out as 0.
    cfg_mag = AW'(cfg_data[N-2:0]);
    cfg_tc  = cfg_data[N-1] ? -cfg_mag : cfg_mag;
    row_ok  = int'(cfg_row) < NPB;
    col_ok  = int'(cfg_col) < NPB;

    // Self-coupling is excluded from the local field.
    wij  = (pi == pj) ? '0 : w[pi][pj];
    term = out[pj] ? wij : -wij;

    z_sum = acc + bias[pi];
    if (z_sum > ZMAX)      z_sat = ZMAX;
    else if (z_sum < ZMIN) z_sat = ZMIN;
    else                   z_sat = z_sum;

    // Low N LFSR bits read as a signed threshold in [-2^(N-1), 2^(N-1)-1].
    r_tc    = {{(AW-N){lfsr[N-1]}}, lfsr[N-1:0]};
    new_bit = force_en[pi] ? force_val[pi] : (z_sat >= r_tc);

    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      pi           <= '0;
      pj           <= '0;
      acc          <= '0;
      lfsr         <= SEED;
      out          <= '0;
      sample_valid <= 1'b0;
      sweep_cnt    <= '0;
      for (int a = 0; a < NPB; a++) begin
        bias[a] <= '0;
        for (int b = 0; b < NPB; b++) w[a][b] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we && row_ok) begin
            if (cfg_bias)    bias[cfg_row]         <= cfg_tc;
            else if (col_ok) w[cfg_row][cfg_col] <= cfg_tc;
          end
          if (run) begin
            state <= ACC;
            pi    <= '0;
            pj    <= '0;
            acc   <= '0;
          end
        end
        ACC: begin
          acc <= acc + term;
          if (pj == IW'(NPB - 1)) state <= UPD;
          else                    pj    <= pj + 1'b1;
        end
        UPD: begin
          out[pi] <= new_bit;
          lfsr    <= lfsr_next;
          acc     <= '0;
          pj      <= '0;
          if (pi == IW'(NPB - 1)) begin
            // run is only sampled at the sweep boundary, so dropping it
            // mid-sweep lets the sweep finish.
            sample_valid <= 1'b1;
            sweep_cnt    <= sweep_cnt + 16'd1;
            pi           <= '0;
            state        <= run ? ACC : IDLE;
          end else begin
            pi    <= pi + 1'b1;
            state <= ACC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_sweep_engine.sv
`timescale 1ns/1ps
module tb_pbit_sweep_engine;

  localparam int          NPB       = 8;
  localparam int          N         = 7;
  localparam int          IW        = 3;
  localparam int          ZMAX      = 63;
  localparam logic [31:0] SEED      = 32'hACE1_2468;
  localparam int          SWEEP_CYC = NPB * (NPB + 1);

  // ---------------- clock / reset / DUT ----------------
  logic           CLK        = 1'b0;
  logic           RST_N      = 1'b0;
  logic           run        = 1'b0;
  logic           cfg_we     = 1'b0;
  logic           cfg_bias   = 1'b0;
  logic [IW-1:0]  cfg_row    = '0;
  logic [IW-1:0]  cfg_col    = '0;
  logic [N-1:0]   cfg_data   = '0;
  logic [NPB-1:0] clamp_mask = '0;
  logic [NPB-1:0] clamp_val  = '0;
  logic           busy;
  logic [NPB-1:0] out;
  logic           sample_valid;
  logic [15:0]    sweep_cnt;
  logic [1:0]     dbg_state;

  always #5 CLK = ~CLK;

  pbit_sweep_engine #(.NPB(NPB), .N(N), .Q(2), .SEED(SEED)) dut (
    .CLK(CLK), .RST_N(RST_N), .run(run), .cfg_we(cfg_we), .cfg_bias(cfg_bias),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_data(cfg_data),
    .clamp_mask(clamp_mask), .clamp_val(clamp_val), .busy(busy), .out(out),
    .sample_valid(sample_valid), .sweep_cnt(sweep_cnt), .dbg_state(dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want test done before it");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model + scoreboard ----------------
  int             total = 0;
  int             bad   = 0;
  int             mw [NPB][NPB];
  int             mb [NPB];
  logic [NPB-1:0] m_out;
  logic [31:0]    m_lfsr;
  int             m_cnt;
  logic [NPB-1:0] exp_q[$];

  function automatic int sm2int(input logic [N-1:0] d);
    int mag;
    mag = int'(d[N-2:0]);
    return d[N-1] ? -mag : mag;
  endfunction

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_out  = '0;
    m_lfsr = SEED;
    m_cnt  = 0;
    for (int a = 0; a < NPB; a++) begin
      mb[a] = 0;
      for (int b = 0; b < NPB; b++) mw[a][b] = 0;
    end
    exp_q.delete();
  endtask

  // One full Gibbs sweep in p-bit order; pushes the final state.
  task automatic model_sweep();
    int acc;
    int z;
    int r;
    for (int i = 0; i < NPB; i++) begin
      acc = 0;
      for (int j = 0; j < NPB; j++)
        if (j != i) acc += m_out[j] ? mw[i][j] : -mw[i][j];
      z = acc + mb[i];
      if (z > ZMAX)  z = ZMAX;
      if (z < -ZMAX) z = -ZMAX;
      r = int'(m_lfsr[N-1:0]);
      if (r >= 2**(N-1)) r -= 2**N;
      m_out[i] = (z >= r);
`ifdef PBIT_CLAMP_EN
      if (clamp_mask[i]) m_out[i] = clamp_val[i];
`endif
      m_lfsr = lfsr_step(m_lfsr);
    end
    exp_q.push_back(m_out);
  endtask

  function automatic logic [NPB-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input logic b, input int row, input int col,
                           input logic [N-1:0] data, input bit upd_model);
    cfg_we   = 1'b1;
    cfg_bias = b;
    cfg_row  = IW'(row);
    cfg_col  = IW'(col);
    cfg_data = data;
    @(negedge CLK);
    cfg_we = 1'b0;
    if (upd_model) begin
      if (b) mb[row] = sm2int(data);
      else   mw[row][col] = sm2int(data);
    end
  endtask

  task automatic wait_sample(output bit got, output int cycles, output logic prev_busy);
    got       = 1'b0;
    cycles    = 0;
    prev_busy = busy;
    while (!got && cycles < 4 * SWEEP_CYC) begin
      prev_busy = busy;
      @(negedge CLK);
      cycles++;
      if (sample_valid) got = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge CLK);
    total++; if (out !== '0) begin bad++; $display("FAIL rst_out: got %h want 00", out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_sv: got %b want 0", sample_valid); end
    total++; if (sweep_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", sweep_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0 (IDLE)", dbg_state); end
    RST_N = 1'b1;
    model_reset();
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_after: busy got %b want 0", busy); end
  endtask

  task automatic test_bias_saturate();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    for (int k = 0; k < NPB; k++) cfg_write(1'b1, k, 0, 7'b0111111, 1'b1);
    run = 1'b1;
    model_sweep();
    @(negedge CLK);
    run = 1'b0;
    wait_sample(got, cyc, pb);
    e = pop_exp();
    total++; if (got !== 1'b1) begin bad++; $display("FAIL sat_sample: got none want pulse"); end
    total++; if (cyc != SWEEP_CYC) begin bad++; $display("FAIL sat_latency: got %0d want %0d", cyc, SWEEP_CYC); end
    total++; if (out !== 8'hFF) begin bad++; $display("FAIL sat_out: got %h want ff", out); end
    total++; if (out !== e) begin bad++; $display("FAIL sat_model: got %h want %h", out, e); end
    m_cnt = (m_cnt + 1) % 65536;
    total++; if (sweep_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", sweep_cnt, m_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_idle: busy got %b want 0", busy); end
    @(negedge CLK);
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL sat_pulse_width: got %b want 0", sample_valid); end
  endtask

  task automatic test_reset_mid_sweep();
    int pulses;
    run = 1'b1;
    @(negedge CLK);
    run = 1'b0;
    repeat (29) @(negedge CLK);   // now inside ACC of p-bit 3
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 RST_N = 1'b0;
    #1;
    total++; if (out !== '0) begin bad++; $display("FAIL mid_rst_out: got %h want 00", out); end
    total++; if (sweep_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", sweep_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_first_edge: busy got %b want 0", busy); end
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      if (sample_valid) pulses++;
      @(negedge CLK);
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_sample: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_neg_zero();
    cfg_write(1'b0, 2, 5, 7'b0001001, 1'b1);
    cfg_write(1'b0, 2, 5, 7'b1000000, 1'b1);
    cfg_write(1'b0, 5, 2, 7'b1000101, 1'b1);
    cfg_write(1'b1, 4, 0, 7'b0000011, 1'b1);
    total++; if (int'(dut.w[2][5]) != 0) begin bad++; $display("FAIL neg_zero: got %0d want 0", int'(dut.w[2][5])); end
    total++; if (int'(dut.w[5][2]) != -5) begin bad++; $display("FAIL neg_five: got %0d want -5", int'(dut.w[5][2])); end
    total++; if (int'(dut.bias[4]) != 3) begin bad++; $display("FAIL bias_three: got %0d want 3", int'(dut.bias[4])); end
  endtask

  task automatic test_random_model();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    localparam int NS = 12;
    for (int r = 0; r < NPB; r++) begin
      cfg_write(1'b1, r, 0, N'($urandom_range(0, 127)), 1'b1);
      for (int c = 0; c < NPB; c++)
        cfg_write(1'b0, r, c, {1'($urandom_range(0, 1)), 6'($urandom_range(0, 20))}, 1'b1);
    end
    run = 1'b1;
    for (int s = 0; s < NS; s++) model_sweep();
    @(negedge CLK);
    for (int s = 0; s < NS; s++) begin
      wait_sample(got, cyc, pb);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rnd_sample%0d: got none want pulse", s); break; end
      e = pop_exp();
      m_cnt = (m_cnt + 1) % 65536;
      total++; if (out !== e) begin bad++; $display("FAIL rnd_out%0d: got %h want %h", s, out, e); end
      total++; if (cyc != SWEEP_CYC) begin bad++; $display("FAIL rnd_interval%0d: got %0d want %0d", s, cyc, SWEEP_CYC); end
      total++; if (sweep_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt%0d: got %0d want %0d", s, sweep_cnt, m_cnt); end
      if (s == NS - 2) run = 1'b0;
    end
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_unbiased();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    int dut_ones [NPB];
    int mdl_ones [NPB];
    int all_ones;
    real rate;
    localparam int NSW = 500;
    do_reset();
    for (int k = 0; k < NPB; k++) begin dut_ones[k] = 0; mdl_ones[k] = 0; end
    run = 1'b1;
    @(negedge CLK);
    for (int s = 0; s < NSW; s++) begin
      model_sweep();
      wait_sample(got, cyc, pb);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL ub_sample%0d: got none want pulse", s); break; end
      e = pop_exp();
      m_cnt = (m_cnt + 1) % 65536;
      total++; if (out !== e) begin bad++; $display("FAIL ub_out%0d: got %h want %h", s, out, e); end
      for (int k = 0; k < NPB; k++) begin
        if (out[k] === 1'b1) dut_ones[k]++;
        if (e[k]) mdl_ones[k]++;
      end
      if (s == NSW - 2) run = 1'b0;
    end
    @(negedge CLK);
    all_ones = 0;
    for (int k = 0; k < NPB; k++) begin
      all_ones += dut_ones[k];
      total++; if (dut_ones[k] != mdl_ones[k]) begin bad++; $display("FAIL ub_ones_bit%0d: got %0d want %0d", k, dut_ones[k], mdl_ones[k]); end
    end
    rate = real'(all_ones) / real'(NSW * NPB);
    total++; if (rate < 0.47 || rate > 0.53) begin bad++; $display("FAIL ub_rate: got %f want 0.50+/-0.03", rate); end
    total++; if (sweep_cnt !== 16'(NSW)) begin bad++; $display("FAIL ub_cnt: got %0d want %0d", sweep_cnt, NSW); end
  endtask

  task automatic test_clamp();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    do_reset();
    cfg_write(1'b0, 1, 0, 7'b0111111, 1'b1);
    for (int v = 1; v >= 0; v--) begin
      clamp_mask = 8'h01;
      clamp_val  = NPB'(v);
      run = 1'b1;
      @(negedge CLK);
      for (int s = 0; s < 10; s++) begin
        model_sweep();
        wait_sample(got, cyc, pb);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL clamp_sample%0d: got none want pulse", s); break; end
        e = pop_exp();
        m_cnt = (m_cnt + 1) % 65536;
        total++; if (out !== e) begin bad++; $display("FAIL clamp_out%0d: got %h want %h", s, out, e); end
`ifdef PBIT_CLAMP_EN
        total++; if (out[0] !== 1'(v)) begin bad++; $display("FAIL clamp_bit0_%0d: got %b want %0d", s, out[0], v); end
        // With the clamp at 0 the field is -63, which still wins against
        // r = -64, so out[1] for that case is judged by the model above.
        if (v == 1) begin
          total++; if (out[1] !== 1'b1) begin bad++; $display("FAIL clamp_bit1_%0d: got %b want 1", s, out[1]); end
        end
`endif
        if (s == 8) run = 1'b0;
      end
      @(negedge CLK);
    end
    clamp_mask = '0;
    clamp_val  = '0;
  endtask

  task automatic test_cfg_while_busy();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    cfg_write(1'b0, 2, 3, 7'b0001010, 1'b1);
    run = 1'b1;
    model_sweep();
    @(negedge CLK);
    repeat (19) @(negedge CLK);
    cfg_write(1'b0, 2, 3, 7'b1011111, 1'b0);
    run = 1'b0;
    wait_sample(got, cyc, pb);
    e = pop_exp();
    m_cnt = (m_cnt + 1) % 65536;
    total++; if (got !== 1'b1) begin bad++; $display("FAIL busy_wr_sample: got none want pulse"); end
    total++; if (cyc != SWEEP_CYC - 20) begin bad++; $display("FAIL busy_wr_end: got %0d want %0d", cyc, SWEEP_CYC - 20); end
    total++; if (out !== e) begin bad++; $display("FAIL busy_wr_out: got %h want %h", out, e); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_wr_idle: got %b want 0", busy); end
    total++; if (pb !== 1'b1) begin bad++; $display("FAIL busy_wr_prev: got %b want 1", pb); end
    total++; if (int'(dut.w[2][3]) != 10) begin bad++; $display("FAIL busy_wr_weight: got %0d want 10", int'(dut.w[2][3])); end
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    bit got; int cyc; logic pb; logic [NPB-1:0] e;
    force dut.sweep_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut.sweep_cnt;
    m_cnt = 65535;
    total++; if (sweep_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset: got %0d want 65535", sweep_cnt); end
    run = 1'b1;
    model_sweep();
    @(negedge CLK);
    run = 1'b0;
    wait_sample(got, cyc, pb);
    e = pop_exp();
    m_cnt = (m_cnt + 1) % 65536;
    total++; if (got !== 1'b1) begin bad++; $display("FAIL wrap_sample: got none want pulse"); end
    total++; if (sweep_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL wrap_cnt: got %0d want %0d", sweep_cnt, m_cnt); end
    total++; if (out !== e) begin bad++; $display("FAIL wrap_out: got %h want %h", out, e); end
    @(negedge CLK);
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL wrap_pulse_width: got %b want 0", sample_valid); end
    total++; if (sweep_cnt !== 16'd0) begin bad++; $display("FAIL wrap_hold: got %0d want 0", sweep_cnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_bias_saturate();
    test_reset_mid_sweep();
    test_neg_zero();
    test_random_model();
    test_unbiased();
    test_clamp();
    test_cfg_while_busy();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
